// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access unit: size codes, FSM states
// and doubleword geometry.
package mem_access_pkg;

  localparam int unsigned DWORD_BYTES = 8;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_e;

  // Number of bytes touched by an access of the given size code.
  function automatic logic [63:0] size_bytes(input logic [1:0] size);
    return 64'd1 << size;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a memory doubleword and right-aligned CPU data:
// store-byte merge and load extract with sign/zero extension.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [63:0] dword,
  input  logic [63:0] wdata,
  input  logic [2:0]  lane,
  input  size_e       size,
  input  logic        sign_ext,
  output logic [63:0] merged,
  output logic [63:0] load_data
);

  logic [63:0] shifted;

  always_comb begin
    merged = dword;
    for (int unsigned i = 0; i < DWORD_BYTES; i++) begin
      if ((i >= 32'(lane)) && (i < 32'(lane) + (32'd1 << size))) begin
        merged[8*i +: 8] = wdata[8*(i - 32'(lane)) +: 8];
      end
    end
  end

  always_comb begin
    shifted   = dword >> {lane, 3'b000};
    load_data = '0;
    unique case (size)
      SIZE_B: load_data = sign_ext ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
      SIZE_H: load_data = sign_ext ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      SIZE_W: load_data = sign_ext ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      SIZE_D: load_data = shifted;
      default: load_data = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for a byte-addressed 64-bit memory.
// Narrow stores are performed as read-modify-write of the containing doubleword.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_fault,
  output logic [63:0] mem_address,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write
);

  localparam logic [63:0] LAST_BASE = 64'(MEM_BYTES - DWORD_BYTES);

  state_e      state;
  logic        wr_q;
  size_e       size_q;
  logic        sgn_q;
  logic [63:0] addr_q;
  logic [63:0] wdata_q;
  logic [63:0] data_q;
  logic        fault_q;

  logic [63:0] req_base;
  logic        req_fault;
  logic [63:0] base_q;
  logic [63:0] merged;
  logic [63:0] load_data;

  always_comb begin
    req_base  = {req_addr[63:3], 3'b000};
    req_fault = ((req_addr & (size_bytes(req_size) - 64'd1)) != '0) ||
                (req_base > LAST_BASE);
    base_q    = {addr_q[63:3], 3'b000};
  end

  mem_lane_align u_align (
    .dword     (mem_rdata),
    .wdata     (wdata_q),
    .lane      (addr_q[2:0]),
    .size      (size_q),
    .sign_ext  (sgn_q),
    .merged    (merged),
    .load_data (load_data)
  );

  always_comb begin
    mem_wdata  = (state == WRITE) ? data_q : '0;
    resp_fault = resp_valid & fault_q;
  end

  // req_ready is a flop so it stays low for the whole cycle in which rst falls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= '0;
      mem_address <= '0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      wr_q        <= 1'b0;
      size_q      <= SIZE_B;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      data_q      <= '0;
      fault_q     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            wr_q      <= req_write;
            size_q    <= size_e'(req_size);
            sgn_q     <= req_signed;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            fault_q   <= req_fault;
            if (req_fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= '0;
            end else if (req_write && (size_e'(req_size) == SIZE_D)) begin
              state       <= WRITE;
              data_q      <= req_wdata;
              mem_write   <= 1'b1;
              mem_address <= req_base;
            end else begin
              state       <= READ;
              mem_read    <= 1'b1;
              mem_address <= req_base;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        READ: begin
          mem_read <= 1'b0;
          if (wr_q) begin
            state     <= WRITE;
            data_q    <= merged;
            mem_write <= 1'b1;
          end else begin
            state       <= RESP;
            data_q      <= mem_rdata;
            mem_address <= '0;
            resp_valid  <= 1'b1;
            resp_rdata  <= load_data;
          end
        end
        WRITE: begin
          state       <= RESP;
          mem_write   <= 1'b0;
          mem_address <= '0;
          resp_valid  <= 1'b1;
          resp_rdata  <= '0;
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          fault_q    <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sanity: both strobes at once would mean the FSM lost its encoding.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(mem_read && mem_write));
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed plan cases plus random
// accesses compared against a byte-array reference memory.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_fault;
  logic [63:0] mem_address;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_read;
  logic        mem_write;

  int checks = 0;
  int errors = 0;

  mem_access_unit #(.MEM_BYTES(128)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_fault  (resp_fault),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_read    (mem_read),
    .mem_write   (mem_write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached memory: combinational read, write commits on the clock edge.
  logic [63:0] tb_mem [16];
  assign mem_rdata = mem_read ? tb_mem[mem_address[6:3]] : 64'h0;
  always @(posedge clk) if (mem_write) tb_mem[mem_address[6:3]] <= mem_wdata;

  // Reference memory, byte granular.
  logic [7:0] ref_mem [128];

  // Expected results from the reference model.
  logic        e_fault;
  logic [63:0] e_rdata;
  int          e_lat;
  int          e_nrd;
  int          e_nwr;
  logic [63:0] e_wdata;

  // Observations from one transaction.
  logic [63:0] r_rdata;
  logic        r_fault;
  int          r_lat;
  int          r_nrd;
  int          r_nwr;
  logic [63:0] r_rd_addr;
  logic [63:0] r_wr_addr;
  logic [63:0] r_wr_data;
  logic        r_both;
  logic        r_to;

  task automatic model_access(input logic w, input logic [1:0] sz, input logic sg,
                              input logic [63:0] a, input logic [63:0] wd);
    int unsigned nb;
    int unsigned ai;
    logic [63:0] base;
    nb      = 32'd1 << sz;
    base    = a & ~64'h7;
    e_fault = ((a % 64'(nb)) != 64'd0) || (base > 64'd120);
    e_rdata = 64'h0;
    e_wdata = 64'h0;
    e_nrd   = 0;
    e_nwr   = 0;
    e_lat   = 1;
    if (e_fault) return;
    ai = 32'(a[6:0]);
    if (!w) begin
      e_lat = 2;
      e_nrd = 1;
      for (int unsigned i = 0; i < nb; i++) e_rdata[8*i +: 8] = ref_mem[ai + i];
      if (sg && nb < 8 && e_rdata[8*nb-1])
        for (int unsigned i = nb; i < 8; i++) e_rdata[8*i +: 8] = 8'hFF;
    end else begin
      for (int unsigned i = 0; i < nb; i++) ref_mem[ai + i] = wd[8*i +: 8];
      for (int unsigned i = 0; i < 8; i++) e_wdata[8*i +: 8] = ref_mem[32'(base[6:0]) + i];
      e_nwr = 1;
      e_nrd = (sz == 2'd3) ? 0 : 1;
      e_lat = (sz == 2'd3) ? 2 : 3;
    end
  endtask

  task automatic run_access(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [63:0] a, input logic [63:0] wd);
    int  g;
    logic done;
    r_rdata = '0; r_fault = 0; r_lat = 0; r_nrd = 0; r_nwr = 0;
    r_rd_addr = '0; r_wr_addr = '0; r_wr_data = '0; r_both = 0; r_to = 0;
    @(negedge clk);
    req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    if (!req_ready) begin r_to = 1; req_valid = 1'b0; return; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    done = 0;
    for (int c = 1; c <= 8 && !done; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (mem_read)  begin r_nrd++; r_rd_addr = mem_address; end
      if (mem_write) begin r_nwr++; r_wr_addr = mem_address; r_wr_data = mem_wdata; end
      if (mem_read && mem_write) r_both = 1;
      if (resp_valid) begin
        r_lat = c; r_rdata = resp_rdata; r_fault = resp_fault; done = 1;
      end
    end
    r_to = !done;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 0; req_write = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, resp_valid, resp_fault, mem_read, mem_write} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000", {req_ready, resp_valid, resp_fault, mem_read, mem_write});
    end
    checks++;
    if ({resp_rdata, mem_address, mem_wdata} !== 192'h0) begin
      errors++;
      $display("FAIL reset_buses got %h %h %h want 0", resp_rdata, mem_address, mem_wdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b want 1", req_ready);
    end
  endtask

  task automatic test_directed;
    model_access(1, 2'd3, 0, 64'h10, 64'h1122334455667788);
    run_access  (1, 2'd3, 0, 64'h10, 64'h1122334455667788);
    checks++;
    if (r_to || r_nwr != 1 || r_nrd != 0 || r_wr_addr !== 64'h10 || r_wr_data !== 64'h1122334455667788 || r_lat != 2) begin
      errors++;
      $display("FAIL dstore to=%0b nwr=%0d nrd=%0d addr=%h data=%h lat=%0d want nwr=1 nrd=0 addr=10 data=1122334455667788 lat=2",
               r_to, r_nwr, r_nrd, r_wr_addr, r_wr_data, r_lat);
    end
    model_access(0, 2'd3, 0, 64'h10, 64'h0);
    run_access  (0, 2'd3, 0, 64'h10, 64'h0);
    checks++;
    if (r_to || r_rdata !== 64'h1122334455667788 || r_fault !== 1'b0 || r_lat != 2) begin
      errors++;
      $display("FAIL dload rdata=%h fault=%b lat=%0d want 1122334455667788 0 2", r_rdata, r_fault, r_lat);
    end
    model_access(1, 2'd0, 0, 64'h13, 64'hAB);
    run_access  (1, 2'd0, 0, 64'h13, 64'hAB);
    checks++;
    if (r_to || r_nrd != 1 || r_rd_addr !== 64'h10 || r_nwr != 1 || r_wr_addr !== 64'h10 ||
        r_wr_data !== 64'h11223344AB667788 || r_lat != 3) begin
      errors++;
      $display("FAIL rmw nrd=%0d rdaddr=%h nwr=%0d wraddr=%h data=%h lat=%0d want 1 10 1 10 11223344ab667788 3",
               r_nrd, r_rd_addr, r_nwr, r_wr_addr, r_wr_data, r_lat);
    end
    model_access(0, 2'd0, 1, 64'h13, 64'h0);
    run_access  (0, 2'd0, 1, 64'h13, 64'h0);
    checks++;
    if (r_to || r_rdata !== 64'hFFFFFFFFFFFFFFAB) begin
      errors++; $display("FAIL lb_signed got %h want ffffffffffffffab", r_rdata);
    end
    model_access(0, 2'd0, 0, 64'h13, 64'h0);
    run_access  (0, 2'd0, 0, 64'h13, 64'h0);
    checks++;
    if (r_to || r_rdata !== 64'h00000000000000AB) begin
      errors++; $display("FAIL lb_unsigned got %h want 00000000000000ab", r_rdata);
    end
  endtask

  task automatic test_faults;
    run_access(0, 2'd1, 0, 64'h11, 64'h0);
    checks++;
    if (r_to || r_fault !== 1'b1 || r_lat != 1 || r_nrd != 0 || r_nwr != 0 || r_rdata !== 64'h0) begin
      errors++;
      $display("FAIL fault_misalign fault=%b lat=%0d nrd=%0d nwr=%0d rdata=%h want 1 1 0 0 0",
               r_fault, r_lat, r_nrd, r_nwr, r_rdata);
    end
    model_access(0, 2'd2, 0, 64'h7C, 64'h0);
    run_access  (0, 2'd2, 0, 64'h7C, 64'h0);
    checks++;
    if (r_to || r_fault !== 1'b0 || r_rd_addr !== 64'h78 || r_rdata !== e_rdata) begin
      errors++;
      $display("FAIL top_word fault=%b addr=%h rdata=%h want 0 78 %h", r_fault, r_rd_addr, r_rdata, e_rdata);
    end
    run_access(0, 2'd3, 0, 64'h80, 64'h0);
    checks++;
    if (r_to || r_fault !== 1'b1 || r_nrd != 0 || r_nwr != 0) begin
      errors++;
      $display("FAIL fault_range fault=%b nrd=%0d nwr=%0d want 1 0 0", r_fault, r_nrd, r_nwr);
    end
  endtask

  task automatic test_random;
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [63:0] a;
    logic [63:0] wd;
    for (int n = 0; n < 80; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = 64'($urandom_range(0, 135));
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      wd = {$urandom, $urandom};
      model_access(w, sz, sg, a, wd);
      run_access  (w, sz, sg, a, wd);
      checks++;
      if (r_to || r_fault !== e_fault || r_rdata !== e_rdata || r_lat != e_lat) begin
        errors++;
        $display("FAIL rand_resp n=%0d w=%0b sz=%0d a=%h fault=%b rdata=%h lat=%0d want %b %h %0d",
                 n, w, sz, a, r_fault, r_rdata, r_lat, e_fault, e_rdata, e_lat);
      end
      checks++;
      if (r_nrd != e_nrd || r_nwr != e_nwr || r_both) begin
        errors++;
        $display("FAIL rand_strobes n=%0d nrd=%0d nwr=%0d both=%b want %0d %0d 0", n, r_nrd, r_nwr, r_both, e_nrd, e_nwr);
      end
      if (e_nwr != 0) begin
        checks++;
        if (r_wr_addr !== (a & ~64'h7) || r_wr_data !== e_wdata) begin
          errors++;
          $display("FAIL rand_wdata n=%0d addr=%h data=%h want %h %h", n, r_wr_addr, r_wr_data, a & ~64'h7, e_wdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_rmw;
    int g;
    @(negedge clk);
    req_write = 1; req_size = 2'd0; req_signed = 0; req_addr = 64'h20; req_wdata = 64'h5A;
    req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_read !== 1'b1 || mem_address !== 64'h20) begin
      errors++; $display("FAIL rmw_read_phase rd=%b addr=%h want 1 20", mem_read, mem_address);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({mem_read, mem_write, req_ready} !== 3'b000 || mem_address !== 64'h0) begin
      errors++;
      $display("FAIL rst_async rd/wr/rdy=%b addr=%h want 000 0", {mem_read, mem_write, req_ready}, mem_address);
    end
    @(posedge clk); #1;
    checks++;
    if (mem_write !== 1'b0) begin
      errors++; $display("FAIL rst_no_write got %b want 0", mem_write);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_ready_after got %b want 1", req_ready);
    end
    model_access(0, 2'd3, 0, 64'h20, 64'h0);
    run_access  (0, 2'd3, 0, 64'h20, 64'h0);
    checks++;
    if (r_to || r_rdata !== e_rdata) begin
      errors++; $display("FAIL rst_mem_unchanged got %h want %h", r_rdata, e_rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] a1, a2, x1, x2;
    int g;
    a1 = 64'(8 * $urandom_range(0, 15));
    a2 = 64'(4 * $urandom_range(0, 31));
    model_access(0, 2'd3, 0, a1, 64'h0); x1 = e_rdata;
    model_access(0, 2'd2, 1, a2, 64'h0); x2 = e_rdata;
    @(negedge clk);
    req_write = 0; req_size = 2'd3; req_signed = 0; req_addr = a1; req_valid = 1'b1;
    g = 0;
    while (!req_ready && g < 20) begin @(negedge clk); g++; end
    @(posedge clk); #1;
    req_size = 2'd2; req_signed = 1; req_addr = a2;
    checks++;
    if ({mem_read, req_ready, resp_valid} !== 3'b100) begin
      errors++; $display("FAIL b2b_read1 rd/rdy/rv=%b want 100", {mem_read, req_ready, resp_valid});
    end
    @(posedge clk); #1;
    checks++;
    if ({mem_read, req_ready, resp_valid} !== 3'b001 || resp_rdata !== x1) begin
      errors++;
      $display("FAIL b2b_resp1 rd/rdy/rv=%b rdata=%h want 001 %h", {mem_read, req_ready, resp_valid}, resp_rdata, x1);
    end
    @(posedge clk); #1;
    checks++;
    if ({mem_read, req_ready, resp_valid} !== 3'b010) begin
      errors++; $display("FAIL b2b_idle rd/rdy/rv=%b want 010", {mem_read, req_ready, resp_valid});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if ({mem_read, req_ready, resp_valid} !== 3'b100 || mem_address !== (a2 & ~64'h7)) begin
      errors++;
      $display("FAIL b2b_read2 rd/rdy/rv=%b addr=%h want 100 %h", {mem_read, req_ready, resp_valid}, mem_address, a2 & ~64'h7);
    end
    @(posedge clk); #1;
    checks++;
    if (resp_valid !== 1'b1 || resp_rdata !== x2) begin
      errors++; $display("FAIL b2b_resp2 rv=%b rdata=%h want 1 %h", resp_valid, resp_rdata, x2);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      tb_mem[i] = {$urandom, $urandom};
      for (int b = 0; b < 8; b++) ref_mem[8*i + b] = tb_mem[i][8*b +: 8];
    end
    test_reset();
    test_directed();
    test_faults();
    test_random();
    test_reset_mid_rmw();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the byte-addressed, 64-bit data-memory interface: mem_address, 64-bit data each way, mem_read and mem_write strobes.
- Sits between the CPU execute/memory stage and the data memory. Accepts one load or store request at a time and returns one response.
- Supports access sizes of byte, halfword, word and doubleword, with zero- or sign-extension on loads.
- Narrow stores are done as a read-modify-write of the aligned doubleword that contains them.

Parameters:
- MEM_BYTES, 128: number of bytes in the attached memory. Must be a multiple of 8.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  a request is present on the req_* inputs.
- req_ready  output  1  the unit can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = doubleword.
- req_signed  input  1  sign-extend on a load; ignored for stores.
- req_addr  input  64  byte address of the access.
- req_wdata  input  64  store data, right-aligned.
- resp_valid  output  1  one-cycle pulse marking completion of the request.
- resp_rdata  output  64  extended load data; 0 for stores and faults.
- resp_fault  output  1  the request was rejected; valid with resp_valid.
- mem_address  output  64  doubleword-aligned address driven to the memory.
- mem_wdata  output  64  write data driven to the memory's data_in.
- mem_rdata  input  64  read data from the memory's data_out (combinational).
- mem_read  output  1  memory read enable.
- mem_write  output  1  memory write enable; the write commits at the next clk edge.

Behaviour:
- Definitions:
  - bytes = 1 << req_size
  - base = addr & ~7
  - lane = addr[2:0]
- Request capture: on the rising edge where state = IDLE and req_valid = 1, the unit latches write, size, signed, addr and wdata, and computes fault.
- Fault condition: (addr mod bytes) != 0, OR base > MEM_BYTES - 8. The comparison is done in 64-bit unsigned arithmetic, with no wrap.
- States and transitions:
  - IDLE: req_ready = 1.
    - Fault -> RESP.
    - Load -> READ.
    - Store with size 3 -> WRITE, with data_q = wdata.
    - Store with size < 3 -> READ.
  - READ: mem_read = 1, mem_address = base.
    - At the clock edge, data_q is loaded from mem_rdata.
    - Load -> RESP.
    - Store: data_q instead gets mem_rdata with bytes [lane .. lane+bytes-1] replaced by the low bytes of wdata; -> WRITE.
  - WRITE: mem_write = 1, mem_address = base, mem_wdata = data_q; -> RESP.
  - RESP: resp_valid = 1; -> IDLE. The response cannot be stalled.
- Load result:
  - The value is (data_q >> 8*lane) truncated to bytes.
  - It is sign-extended when signed = 1, otherwise zero-extended, to 64 bits.
  - It is held in a register and driven on resp_rdata only in RESP; resp_rdata = 0 otherwise.
- Outputs outside active states:
  - mem_read, mem_write, mem_address and mem_wdata are 0 outside READ/WRITE.
  - mem_read and mem_write are never high together.
- Latency, with the accept edge as E0:
  - Load: READ in cycle E0-E1; resp_valid in cycle E1-E2.
  - Doubleword store: WRITE in E0-E1 (memory updated at E1); resp_valid in E1-E2.
  - Narrow store: READ E0-E1, WRITE E1-E2 (memory updated at E2); resp_valid in E2-E3.
  - Fault: resp_valid in E0-E1, resp_fault = 1, no memory strobe.
- Throughput: req_ready = 0 in every state except IDLE. A request held on req_valid while busy is accepted on the first edge back in IDLE.
- Reset: while rst is high, and immediately on its assertion:
  - state = IDLE.
  - All outputs are 0, including req_ready.
  - All captured registers are 0.
- Reset mid-operation: the operation is abandoned. A write whose WRITE cycle is cut by rst before the edge must not commit.
- req_ready rises in the first cycle after rst deasserts.

Decomposition:
- Shared package mem_access_pkg:
  - Size encodings SIZE_B, SIZE_H, SIZE_W, SIZE_D.
  - State enum: IDLE, READ, WRITE, RESP.
  - Constant DWORD_BYTES = 8.
- One combinational sub-module, mem_lane_align. It covers:
  - the merge of store bytes into a doubleword at lane;
  - the extraction and sign/zero extension of load data from a lane.
- The top level holds the state machine and the captured registers.

Test Plan:
- Doubleword store then load: store 0x1122334455667788 at 0x10, then load D at 0x10.
  - One mem_write at address 0x10 with data 0x1122334455667788.
  - resp_rdata = 0x1122334455667788, resp_fault = 0.
- Narrow store read-modify-write: following the first test, store byte 0xAB at 0x13.
  - mem_read at 0x10, then mem_write at 0x10 with data 0x11223344AB667788.
  - resp_valid arrives 3 cycles after the accept edge.
- Extension: load B at 0x13 with req_signed = 1, then with req_signed = 0.
  - Signed: resp_rdata = 0xFFFFFFFFFFFFFFAB.
  - Unsigned: resp_rdata = 0x00000000000000AB.
- Faults:
  - Load H at 0x11: resp_fault = 1, one cycle after accept, no mem strobe.
  - Load W at 0x7C: no fault; mem_address = 0x78.
  - Load D at 0x80: resp_fault = 1.
- Reset mid-RMW: issue store B to 0x20, then pulse rst during READ.
  - mem_read drops immediately, no mem_write occurs, memory at 0x20 is unchanged.
  - req_ready = 1 in the first cycle after rst falls.
- Backpressure: hold req_valid with two back-to-back loads.
  - The second request is accepted only on the edge after the first one's RESP cycle.
  - req_ready = 0 throughout READ and RESP.
